ingress_dispatcher: RTL and testbench

- Stage directly downstream of the ingress offset stage; consumes its dispatcher packet stream (134-bit words plus a per-packet valid flag).
- Buffers whole packets and steers each one to one of two destinations: the transmit path (XMIT) or the CPU path (CPU).
- Discards packets that are invalid or flagged for drop, and keeps 32-bit statistics counters.

---
 rtl/ingress_dispatcher_pkg.sv | 43 ++++
 rtl/ingress_dispatcher_sync_fifo_fwft.sv | 61 ++++++
 rtl/ingress_dispatcher.sv | 184 ++++++++++++++++++
 tb/tb_ingress_dispatcher.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_dispatcher_pkg.sv
// Shared definitions for the ingress dispatcher slice.
// Word layout: [133:132] header code, [131:128] invalid-byte count, [127:0] data.
// Head word data bits 127 (drop) and 126 (to CPU) steer the packet.
package ingress_dispatcher_pkg;

  localparam int unsigned WORD_W = 134;

  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_BODY = 2'b11;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  localparam int unsigned DROP_BIT = 127;
  localparam int unsigned CPU_BIT  = 126;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECIDE  = 2'd1,
    SEND    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    XMIT = 2'd0,
    CPU  = 2'd1,
    DROP = 2'd2
  } dest_t;

  // Drop flag and invalid packets take priority over CPU steering.
  function automatic dest_t route_pkt(input logic valid, input logic [WORD_W-1:0] head);
    if (!valid || head[DROP_BIT]) return DROP;
    if (head[CPU_BIT]) return CPU;
    return XMIT;
  endfunction

  function automatic logic is_tail(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 2] == HDR_TAIL;
  endfunction

  function automatic logic is_body(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: 2] == HDR_BODY;
  endfunction

endpackage

// File: rtl/ingress_dispatcher_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears pointers/count)
//   wr_en, wr_data      write strobe and data; writes when full are dropped
//   rd_en, rd_data      pop strobe; rd_data always shows the head entry
//   empty               no entries held
//   count               number of entries held (0..2**AW)
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int unsigned     DEPTH    = 1 << AW;
  localparam logic [AW:0]     FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream must honour almostfull; a write into a full FIFO is a protocol error.
  overflow_chk : assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/ingress_dispatcher.sv
// Ingress dispatcher: buffers whole packets from the offset stage and steers
// each one to the transmit (XMIT) or CPU path, or discards it.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   in_ingress_pkt_wr/_pkt         inbound word stream (134-bit words)
//   in_ingress_valid_wr/_valid     per-packet forward(1)/drop(0) flag
//   out_ingress_pkt_almostfull     registered backpressure to upstream
//   out_xmit_* / in_xmit_*         XMIT word/flag outputs and backpressure
//   out_cpu_*  / in_cpu_*          CPU word/flag outputs and backpressure
//   out_xmit_cnt/_cpu_cnt/_drop_cnt  32-bit wrapping packet counters
module ingress_dispatcher
  import ingress_dispatcher_pkg::*;
#(
  parameter int unsigned PKT_FIFO_AW   = 8,
  parameter int unsigned VAL_FIFO_AW   = 6,
  parameter int unsigned PKT_AF_MARGIN = 100,
  parameter int unsigned VAL_AF_MARGIN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_ingress_pkt_wr,
  input  logic [WORD_W-1:0] in_ingress_pkt,
  input  logic              in_ingress_valid_wr,
  input  logic              in_ingress_valid,
  output logic              out_ingress_pkt_almostfull,
  output logic              out_xmit_pkt_wr,
  output logic [WORD_W-1:0] out_xmit_pkt,
  output logic              out_xmit_valid_wr,
  output logic              out_xmit_valid,
  input  logic              in_xmit_pkt_almostfull,
  output logic              out_cpu_pkt_wr,
  output logic [WORD_W-1:0] out_cpu_pkt,
  output logic              out_cpu_valid_wr,
  output logic              out_cpu_valid,
  input  logic              in_cpu_pkt_almostfull,
  output logic [31:0]       out_xmit_cnt,
  output logic [31:0]       out_cpu_cnt,
  output logic [31:0]       out_drop_cnt
);

  localparam int unsigned PKT_DEPTH = 1 << PKT_FIFO_AW;
  localparam int unsigned VAL_DEPTH = 1 << VAL_FIFO_AW;

  logic [WORD_W-1:0]    pkt_dout;
  logic                 pkt_empty;
  logic [PKT_FIFO_AW:0] pkt_count;
  logic                 pkt_rd;
  logic [0:0]           val_din;
  logic [0:0]           val_dout;
  logic                 val_empty;
  logic [VAL_FIFO_AW:0] val_count;
  logic                 val_rd;
  logic [31:0]          pkt_free;
  logic [31:0]          val_free;

  state_t state;
  dest_t  dest;
  dest_t  head_dest;
  logic   dest_af;
  logic   decide_go;

  assign val_din = in_ingress_valid;

  sync_fifo_fwft #(.WIDTH(WORD_W), .AW(PKT_FIFO_AW)) u_pkt_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (in_ingress_pkt_wr),
    .wr_data (in_ingress_pkt),
    .rd_en   (pkt_rd),
    .rd_data (pkt_dout),
    .empty   (pkt_empty),
    .count   (pkt_count)
  );

  sync_fifo_fwft #(.WIDTH(1), .AW(VAL_FIFO_AW)) u_val_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (in_ingress_valid_wr),
    .wr_data (val_din),
    .rd_en   (val_rd),
    .rd_data (val_dout),
    .empty   (val_empty),
    .count   (val_count)
  );

  assign pkt_free = PKT_DEPTH - 32'(pkt_count);
  assign val_free = VAL_DEPTH - 32'(val_count);

  // DECIDE only leaves IDLE with the valid FIFO non-empty, and it also waits
  // for the head word itself since the flag may overtake the packet words.
  always_comb begin
    head_dest = route_pkt(val_dout[0], pkt_dout);
    dest_af   = ((head_dest == XMIT) && in_xmit_pkt_almostfull) ||
                ((head_dest == CPU)  && in_cpu_pkt_almostfull);
    decide_go = (state == DECIDE) && !pkt_empty && !dest_af;
    val_rd    = decide_go;
    pkt_rd    = ((state == SEND) || (state == DISCARD)) && !pkt_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                      <= IDLE;
      dest                       <= XMIT;
      out_ingress_pkt_almostfull <= 1'b0;
      out_xmit_pkt_wr            <= 1'b0;
      out_xmit_pkt               <= '0;
      out_xmit_valid_wr          <= 1'b0;
      out_xmit_valid             <= 1'b0;
      out_cpu_pkt_wr             <= 1'b0;
      out_cpu_pkt                <= '0;
      out_cpu_valid_wr           <= 1'b0;
      out_cpu_valid              <= 1'b0;
      out_xmit_cnt               <= '0;
      out_cpu_cnt                <= '0;
      out_drop_cnt               <= '0;
    end else begin
      out_ingress_pkt_almostfull <= (pkt_free < PKT_AF_MARGIN) || (val_free < VAL_AF_MARGIN);
      out_xmit_pkt_wr   <= 1'b0;
      out_xmit_valid_wr <= 1'b0;
      out_xmit_valid    <= 1'b0;
      out_cpu_pkt_wr    <= 1'b0;
      out_cpu_valid_wr  <= 1'b0;
      out_cpu_valid     <= 1'b0;

      case (state)
        IDLE: begin
          if (!val_empty) state <= DECIDE;
        end

        DECIDE: begin
          if (decide_go) begin
            dest <= head_dest;
            if (head_dest == DROP) state <= DISCARD;
            else                   state <= SEND;
          end
        end

        SEND: begin
          if (!pkt_empty) begin
            if (dest == CPU) begin
              out_cpu_pkt_wr <= 1'b1;
              out_cpu_pkt    <= pkt_dout;
            end else begin
              out_xmit_pkt_wr <= 1'b1;
              out_xmit_pkt    <= pkt_dout;
            end
            if (is_tail(pkt_dout)) begin
              if (dest == CPU) begin
                out_cpu_valid_wr <= 1'b1;
                out_cpu_valid    <= 1'b1;
                out_cpu_cnt      <= out_cpu_cnt + 32'd1;
              end else begin
                out_xmit_valid_wr <= 1'b1;
                out_xmit_valid    <= 1'b1;
                out_xmit_cnt      <= out_xmit_cnt + 32'd1;
              end
              state <= IDLE;
            end
          end
        end

        DISCARD: begin
          if (!pkt_empty && is_tail(pkt_dout)) begin
            out_drop_cnt <= out_drop_cnt + 32'd1;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The word examined in DECIDE must be a head; anything else means the
  // stream lost framing upstream.
  head_chk : assert property (@(posedge clk) disable iff (!reset)
    (state == DECIDE && !pkt_empty) |-> (pkt_dout[WORD_W-1 -: 2] == HDR_HEAD));

  // Words popped in SEND carry a body or tail code after the head.
  frame_chk : assert property (@(posedge clk) disable iff (!reset)
    (state == SEND && !pkt_empty && !is_tail(pkt_dout)) |->
      (is_body(pkt_dout) || (pkt_dout[WORD_W-1 -: 2] == HDR_HEAD)));

endmodule

// File: tb/tb_ingress_dispatcher.sv
module tb_ingress_dispatcher;
  import ingress_dispatcher_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_ingress_pkt_wr;
  logic [WORD_W-1:0] in_ingress_pkt;
  logic              in_ingress_valid_wr;
  logic              in_ingress_valid;
  logic              out_ingress_pkt_almostfull;
  logic              out_xmit_pkt_wr;
  logic [WORD_W-1:0] out_xmit_pkt;
  logic              out_xmit_valid_wr;
  logic              out_xmit_valid;
  logic              in_xmit_pkt_almostfull;
  logic              out_cpu_pkt_wr;
  logic [WORD_W-1:0] out_cpu_pkt;
  logic              out_cpu_valid_wr;
  logic              out_cpu_valid;
  logic              in_cpu_pkt_almostfull;
  logic [31:0]       out_xmit_cnt;
  logic [31:0]       out_cpu_cnt;
  logic [31:0]       out_drop_cnt;

  int unsigned       n_tests = 0;
  int unsigned       n_fail  = 0;
  logic [WORD_W-1:0] xq[$];
  logic [WORD_W-1:0] cq[$];
  int unsigned       mon_x = 0;
  int unsigned       mon_c = 0;
  logic [31:0]       exp_x = '0;
  logic [31:0]       exp_c = '0;
  logic [31:0]       exp_d = '0;
  logic [WORD_W-1:0] sw[6];

  always #5 clk = ~clk;

  ingress_dispatcher dut (
    .clk                        (clk),
    .reset                      (reset),
    .in_ingress_pkt_wr          (in_ingress_pkt_wr),
    .in_ingress_pkt             (in_ingress_pkt),
    .in_ingress_valid_wr        (in_ingress_valid_wr),
    .in_ingress_valid           (in_ingress_valid),
    .out_ingress_pkt_almostfull (out_ingress_pkt_almostfull),
    .out_xmit_pkt_wr            (out_xmit_pkt_wr),
    .out_xmit_pkt               (out_xmit_pkt),
    .out_xmit_valid_wr          (out_xmit_valid_wr),
    .out_xmit_valid             (out_xmit_valid),
    .in_xmit_pkt_almostfull     (in_xmit_pkt_almostfull),
    .out_cpu_pkt_wr             (out_cpu_pkt_wr),
    .out_cpu_pkt                (out_cpu_pkt),
    .out_cpu_valid_wr           (out_cpu_valid_wr),
    .out_cpu_valid              (out_cpu_valid),
    .in_cpu_pkt_almostfull      (in_cpu_pkt_almostfull),
    .out_xmit_cnt               (out_xmit_cnt),
    .out_cpu_cnt                (out_cpu_cnt),
    .out_drop_cnt               (out_drop_cnt)
  );

  task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard for each emitted word.
  always @(negedge clk) begin
    logic [WORD_W-1:0] e;
    logic              tail_x;
    logic              tail_c;
    if (reset) begin
      tail_x = 1'b0;
      tail_c = 1'b0;
      if (out_xmit_pkt_wr) begin
        mon_x++;
        check("xmit_expected", WORD_W'(xq.size() != 0), WORD_W'(1));
        if (xq.size() != 0) begin
          e = xq.pop_front();
          check("xmit_word", out_xmit_pkt, e);
          tail_x = (e[WORD_W-1 -: 2] == HDR_TAIL);
        end
      end
      if (out_xmit_valid_wr || tail_x)
        check("xmit_valid", WORD_W'({out_xmit_valid_wr, out_xmit_valid}), WORD_W'({tail_x, tail_x}));
      if (out_cpu_pkt_wr) begin
        mon_c++;
        check("cpu_expected", WORD_W'(cq.size() != 0), WORD_W'(1));
        if (cq.size() != 0) begin
          e = cq.pop_front();
          check("cpu_word", out_cpu_pkt, e);
          tail_c = (e[WORD_W-1 -: 2] == HDR_TAIL);
        end
      end
      if (out_cpu_valid_wr || tail_c)
        check("cpu_valid", WORD_W'({out_cpu_valid_wr, out_cpu_valid}), WORD_W'({tail_c, tail_c}));
    end
  end

  function automatic logic [WORD_W-1:0] mk_word(input int unsigned idx, input int unsigned n,
                                                 input logic [1:0] flags);
    logic [WORD_W-1:0] w;
    w[127:0] = {$urandom, $urandom, $urandom, $urandom};
    w[133:132] = (idx == 0) ? HDR_HEAD : ((idx == n - 1) ? HDR_TAIL : HDR_BODY);
    w[131:128] = (idx == n - 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    if (idx == 0) w[127:126] = flags;
    return w;
  endfunction

  task automatic expect_word(input logic [WORD_W-1:0] w, input logic [1:0] flags, input logic v);
    if (v && !flags[1]) begin
      if (flags[0]) cq.push_back(w);
      else          xq.push_back(w);
    end
  endtask

  task automatic count_pkt(input logic [1:0] flags, input logic v);
    if (!v || flags[1]) exp_d++;
    else if (flags[0])  exp_c++;
    else                exp_x++;
  endtask

  task automatic put_word(input logic [WORD_W-1:0] w);
    in_ingress_pkt_wr = 1'b1;
    in_ingress_pkt    = w;
    @(negedge clk);
    in_ingress_pkt_wr = 1'b0;
  endtask

  task automatic put_valid(input logic v);
    in_ingress_valid_wr = 1'b1;
    in_ingress_valid    = v;
    @(negedge clk);
    in_ingress_valid_wr = 1'b0;
  endtask

  task automatic wait_room();
    int unsigned n = 0;
    while (out_ingress_pkt_almostfull && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("room_timeout", WORD_W'(out_ingress_pkt_almostfull), '0);
  endtask

  task automatic send_pkt(input int unsigned n, input logic [1:0] flags, input logic v);
    logic [WORD_W-1:0] w;
    wait_room();
    for (int unsigned i = 0; i < n; i++) begin
      w = mk_word(i, n, flags);
      expect_word(w, flags, v);
      put_word(w);
    end
    put_valid(v);
    count_pkt(flags, v);
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    while (n < 3000 && !(xq.size() == 0 && cq.size() == 0 && out_xmit_cnt == exp_x &&
                         out_cpu_cnt == exp_c && out_drop_cnt == exp_d)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_xmit_cnt"}, WORD_W'(out_xmit_cnt), WORD_W'(exp_x));
    check({tag, "_cpu_cnt"},  WORD_W'(out_cpu_cnt),  WORD_W'(exp_c));
    check({tag, "_drop_cnt"}, WORD_W'(out_drop_cnt), WORD_W'(exp_d));
    check({tag, "_pending"},  WORD_W'(xq.size() + cq.size()), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    int unsigned base;

    reset = 1'b0;
    in_ingress_pkt_wr = 1'b0;
    in_ingress_pkt = '0;
    in_ingress_valid_wr = 1'b0;
    in_ingress_valid = 1'b0;
    in_xmit_pkt_almostfull = 1'b0;
    in_cpu_pkt_almostfull = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_af",       WORD_W'(out_ingress_pkt_almostfull), '0);
    check("rst_strobes",  WORD_W'({out_xmit_pkt_wr, out_xmit_valid_wr, out_cpu_pkt_wr, out_cpu_valid_wr}), '0);
    check("rst_counts",   WORD_W'({out_xmit_cnt, out_cpu_cnt, out_drop_cnt}), '0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // Plain XMIT packet and first-word latency.
    send_pkt(4, 2'b00, 1'b1);
    lat = 0;
    while (!out_xmit_pkt_wr && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("xmit_latency", WORD_W'(lat), WORD_W'(3));
    drain("xmit1");
    check("xmit1_words", WORD_W'(mon_x), WORD_W'(4));

    // CPU-steered packet.
    send_pkt(3, 2'b01, 1'b1);
    drain("cpu1");
    check("cpu1_words", WORD_W'(mon_c), WORD_W'(3));
    check("cpu1_no_xmit", WORD_W'(mon_x), WORD_W'(4));

    // Drops: invalid flag, drop bit, drop bit winning over CPU bit.
    send_pkt(5, 2'b00, 1'b0);
    send_pkt(4, 2'b10, 1'b1);
    send_pkt(2, 2'b11, 1'b1);
    drain("drop");
    check("drop_no_words", WORD_W'(mon_x + mon_c), WORD_W'(7));
    check("drop_pkt_fifo_empty", WORD_W'(dut.pkt_count), '0);
    check("drop_val_fifo_empty", WORD_W'(dut.val_count), '0);

    // Destination backpressure holds the packet in DECIDE.
    base = mon_x;
    in_xmit_pkt_almostfull = 1'b1;
    send_pkt(5, 2'b00, 1'b1);
    repeat (20) @(negedge clk);
    check("hold_no_words", WORD_W'(mon_x), WORD_W'(base));
    check("hold_xmit_cnt", WORD_W'(out_xmit_cnt), WORD_W'(exp_x - 32'd1));
    in_xmit_pkt_almostfull = 1'b0;
    drain("hold");
    check("hold_words", WORD_W'(mon_x - base), WORD_W'(5));

    // Fill toward the almostfull threshold while the destination is blocked.
    in_xmit_pkt_almostfull = 1'b1;
    send_pkt(95, 2'b00, 1'b1);
    check("af_at_95", WORD_W'(out_ingress_pkt_almostfull), '0);
    send_pkt(61, 2'b00, 1'b1);
    check("af_at_156", WORD_W'(out_ingress_pkt_almostfull), '0);
    send_pkt(95, 2'b00, 1'b1);
    check("af_at_251", WORD_W'(out_ingress_pkt_almostfull), WORD_W'(1));
    in_xmit_pkt_almostfull = 1'b0;
    send_pkt(95, 2'b00, 1'b1);
    drain("b2b");
    check("b2b_af_clear", WORD_W'(out_ingress_pkt_almostfull), '0);

    // Valid flag overtakes the packet: SEND stalls on an empty FIFO.
    base = mon_x;
    for (int unsigned i = 0; i < 6; i++) begin
      sw[i] = mk_word(i, 6, 2'b00);
      expect_word(sw[i], 2'b00, 1'b1);
    end
    put_word(sw[0]);
    put_word(sw[1]);
    put_valid(1'b1);
    count_pkt(2'b00, 1'b1);
    repeat (10) @(negedge clk);
    check("stall_partial_words", WORD_W'(mon_x - base), WORD_W'(2));
    check("stall_xmit_cnt", WORD_W'(out_xmit_cnt), WORD_W'(exp_x - 32'd1));
    for (int unsigned i = 2; i < 6; i++) put_word(sw[i]);
    drain("stall");
    check("stall_words", WORD_W'(mon_x - base), WORD_W'(6));

    // Asynchronous reset in the middle of an outgoing packet.
    base = mon_x;
    send_pkt(20, 2'b00, 1'b1);
    repeat (6) @(negedge clk);
    check("mid_active", WORD_W'(mon_x != base), WORD_W'(1));
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_strobes", WORD_W'({out_xmit_pkt_wr, out_xmit_valid_wr, out_cpu_pkt_wr, out_cpu_valid_wr}), '0);
    check("mid_rst_xmit_pkt", out_xmit_pkt, '0);
    check("mid_rst_cpu_pkt",  out_cpu_pkt, '0);
    check("mid_rst_counts",   WORD_W'({out_xmit_cnt, out_cpu_cnt, out_drop_cnt}), '0);
    check("mid_rst_af",       WORD_W'(out_ingress_pkt_almostfull), '0);
    xq.delete();
    cq.delete();
    exp_x = '0;
    exp_c = '0;
    exp_d = '0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    send_pkt(3, 2'b00, 1'b1);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
